// File: rtl/relu_quant_pack_if.sv
// Beat input from bias-add and valid/ready write-back stream of relu_quant_pack.
interface relu_quant_pack_if;
    logic               src_valid;
    logic signed [31:0] src_0;
    logic signed [31:0] src_1;
    logic signed [31:0] src_2;
    logic signed [31:0] src_3;
    logic signed [31:0] src_4;
    logic signed [31:0] src_5;
    logic signed [31:0] src_6;
    logic signed [31:0] src_7;
    logic [4:0]         shift;
    logic               relu_en;
    logic               dst_valid;
    logic               dst_ready;
    logic [63:0]        dst_data;

    modport master (
        output src_valid, src_0, src_1, src_2, src_3, src_4, src_5, src_6, src_7,
        output shift, relu_en, dst_ready,
        input  dst_valid, dst_data
    );

    modport slave (
        input  src_valid, src_0, src_1, src_2, src_3, src_4, src_5, src_6, src_7,
        input  shift, relu_en, dst_ready,
        output dst_valid, dst_data
    );
endinterface

// File: rtl/relu_quant_pack.sv
// Per-lane ReLU, rounding shift and int8 saturation of eight accumulators,
// packed into a 64-bit word and buffered in a small FIFO for the write-back path.
module relu_quant_pack #(
    parameter int FIFO_DEPTH = 4,
    parameter int SAT_CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 enable,
    relu_quant_pack_if.slave     bus,
    output logic                 overflow,
    output logic [SAT_CNT_W-1:0] sat_cnt
);
    localparam int DATA_W = 32;
    localparam int LANES  = 8;
    localparam int AW     = $clog2(FIFO_DEPTH);

    // 33-bit arithmetic keeps the rounding bias from wrapping at the positive limit.
    function automatic logic signed [DATA_W:0] round_shift(
        input logic signed [DATA_W-1:0] x,
        input logic                     relu,
        input logic [4:0]               sh
    );
        logic signed [DATA_W:0] v;
        logic signed [DATA_W:0] bias;
        v    = (relu && x < 0) ? '0 : {x[DATA_W-1], x};
        bias = (sh == 5'd0) ? '0 : ((DATA_W+1)'(1) << (sh - 5'd1));
        return (v + bias) >>> sh;
    endfunction

    function automatic logic is_sat(input logic signed [DATA_W:0] r);
        return (r > 33'sd127) || (r < -33'sd128);
    endfunction

    function automatic logic [7:0] sat_int8(input logic signed [DATA_W:0] r);
        if (r > 33'sd127) begin
            return 8'h7F;
        end else if (r < -33'sd128) begin
            return 8'h80;
        end
        return r[7:0];
    endfunction

    logic signed [DATA_W-1:0] lane_in [LANES];
    logic signed [DATA_W-1:0] lane_p1 [LANES];
    logic [4:0]               shift_p1;
    logic                     relu_p1;
    logic                     vld_p1;

    logic signed [DATA_W:0]   rnd [LANES];
    logic [8*LANES-1:0]       word_q;
    logic [3:0]               nsat_q;
    logic [8*LANES-1:0]       word_p2;
    logic [3:0]               nsat_p2;
    logic                     vld_p2;

    assign lane_in[0] = bus.src_0;
    assign lane_in[1] = bus.src_1;
    assign lane_in[2] = bus.src_2;
    assign lane_in[3] = bus.src_3;
    assign lane_in[4] = bus.src_4;
    assign lane_in[5] = bus.src_5;
    assign lane_in[6] = bus.src_6;
    assign lane_in[7] = bus.src_7;

    // ---- S1: capture beat ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= bus.src_valid && enable;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.src_valid && enable) begin
            lane_p1  <= lane_in;
            shift_p1 <= bus.shift;
            relu_p1  <= bus.relu_en;
        end
    end

    // ---- S2: quantize and pack ----
    always_comb begin
        word_q = '0;
        nsat_q = '0;
        for (int i = 0; i < LANES; i++) begin
            rnd[i]           = round_shift(lane_p1[i], relu_p1, shift_p1);
            word_q[8*i +: 8] = sat_int8(rnd[i]);
            nsat_q           = nsat_q + {3'd0, is_sat(rnd[i])};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p2 <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p1) begin
            word_p2 <= word_q;
            nsat_p2 <= nsat_q;
        end
    end

    // ---- FIFO write / read ----
    logic [8*LANES-1:0] mem [FIFO_DEPTH];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic               empty;
    logic               full;
    logic               pop;
    logic               push;
    logic [SAT_CNT_W:0] sat_sum;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = !empty && bus.dst_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push    = vld_p2 && (!full || pop);
    assign sat_sum = {1'b0, sat_cnt} + (SAT_CNT_W+1)'(nsat_p2);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            sat_cnt  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (vld_p2 && !push) begin
                overflow <= 1'b1;
            end
            if (vld_p2) begin
                sat_cnt <= sat_sum[SAT_CNT_W] ? '1 : sat_sum[SAT_CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= word_p2;
        end
    end

    assign bus.dst_valid = !empty;
    assign bus.dst_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
endmodule

// File: tb/tb_relu_quant_pack.sv
// Self-checking bench for relu_quant_pack: constant vector table, directed
// FIFO/reset sequences and randomized traffic against a queue-based model.
module tb_relu_quant_pack;
    localparam int     DEPTH   = 4;
    localparam int     SW      = 16;
    localparam longint SAT_MAX = (longint'(1) << SW) - 1;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          enable = 1'b0;
    logic          overflow;
    logic [SW-1:0] sat_cnt;

    relu_quant_pack_if bus ();

    relu_quant_pack #(.FIFO_DEPTH(DEPTH), .SAT_CNT_W(SW)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .enable   (enable),
        .bus      (bus),
        .overflow (overflow),
        .sat_cnt  (sat_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          v;
        logic [63:0] w;
        int          n;
    } stg_t;

    stg_t        m_s1;
    stg_t        m_s2;
    logic [63:0] m_q [$];
    logic        m_ovf;
    longint      m_sat;
    logic [7:0]  popped [$];
    int          exp_ids [$];

    typedef struct {
        logic [7:0][31:0] lanes;
        logic [4:0]       shift;
        logic             relu;
        logic [63:0]      data;
        int               sat;
    } vec_t;

    vec_t vecs [5];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Spec rules in plain integer arithmetic: floor((v + 2^sh/2) / 2^sh), then clamp.
    function automatic void quant(input logic [7:0][31:0] l, input logic [4:0] sh, input logic re,
                                  output logic [63:0] w, output int n);
        longint x, v, den, num, r;
        w = '0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            x   = longint'($signed(l[i]));
            v   = (re && x < 0) ? 0 : x;
            den = longint'(1) << sh;
            num = v + den / 2;
            r   = num / den;
            if ((num % den != 0) && num < 0) r = r - 1;
            if (r > 127) begin
                w[8*i +: 8] = 8'h7F;
                n++;
            end else if (r < -128) begin
                w[8*i +: 8] = 8'h80;
                n++;
            end else begin
                w[8*i +: 8] = r[7:0];
            end
        end
    endfunction

    task automatic drive(input logic v, input logic [7:0][31:0] l, input logic [4:0] sh, input logic re);
        bus.src_valid = v;
        bus.src_0 = l[0]; bus.src_1 = l[1]; bus.src_2 = l[2]; bus.src_3 = l[3];
        bus.src_4 = l[4]; bus.src_5 = l[5]; bus.src_6 = l[6]; bus.src_7 = l[7];
        bus.shift   = sh;
        bus.relu_en = re;
    endtask

    task automatic idle();
        drive(1'b0, '0, 5'd0, 1'b0);
    endtask

    task automatic check_model();
        chk("dst_valid", bus.dst_valid, m_q.size() > 0);
        chk("dst_data", bus.dst_data, (m_q.size() > 0) ? m_q[0] : 64'd0);
        chk("overflow", overflow, m_ovf);
        chk("sat_cnt", sat_cnt, 64'(m_sat));
    endtask

    // One clock: advance the model from the inputs seen before the edge, then compare.
    task automatic step();
        logic [7:0][31:0] l;
        logic [63:0]      w;
        int               n;
        int               sz;
        bit               pop;
        sz  = m_q.size();
        pop = (sz > 0) && (bus.dst_ready === 1'b1);
        if (bus.dst_valid === 1'b1 && bus.dst_ready === 1'b1) popped.push_back(bus.dst_data[7:0]);
        if (pop) void'(m_q.pop_front());
        if (m_s2.v) begin
            if (sz < DEPTH || pop) m_q.push_back(m_s2.w);
            else m_ovf = 1'b1;
            m_sat = m_sat + m_s2.n;
            if (m_sat > SAT_MAX) m_sat = SAT_MAX;
        end
        m_s2   = m_s1;
        m_s1.v = (bus.src_valid === 1'b1) && (enable === 1'b1);
        l = {bus.src_7, bus.src_6, bus.src_5, bus.src_4, bus.src_3, bus.src_2, bus.src_1, bus.src_0};
        quant(l, bus.shift, bus.relu_en, w, n);
        m_s1.w = w;
        m_s1.n = n;
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        idle();
        rstn = 1'b0;
        #2;
        chk("rst_dst_valid", bus.dst_valid, 0);
        chk("rst_dst_data", bus.dst_data, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_sat_cnt", sat_cnt, 0);
        m_s1.v = 1'b0;
        m_s2.v = 1'b0;
        m_q.delete();
        m_ovf = 1'b0;
        m_sat = 0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    function automatic logic [31:0] rnd_lane();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 400)) - 32'd200;
            2:       return ($urandom_range(0, 1) ? 32'h7FFF_FFF0 : 32'h8000_0000) + 32'($urandom_range(0, 15));
            default: return 32'($urandom_range(0, 70000)) - 32'd35000;
        endcase
    endfunction

    initial begin
        logic [7:0][31:0] l;
        int rdy_pct;

        vecs[0] = '{{32'hFFFF_FFFF, 32'd0, 32'd100, 32'hFFFF_FC18, 32'h7FFF_FFFF, 32'hFFFF_FFFB, 32'd300, 32'd5},
                    5'd1, 1'b0, 64'h0000_3280_7FFE_7F03, 3};
        vecs[1] = '{{32'hFFFF_FFFF, 32'd0, 32'd100, 32'hFFFF_FC18, 32'h7FFF_FFFF, 32'hFFFF_FFFB, 32'd300, 32'd5},
                    5'd1, 1'b1, 64'h0000_3200_7F00_7F03, 2};
        vecs[2] = '{{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FF7F, 32'hFFFF_FF80, 32'd128, 32'd127},
                    5'd0, 1'b0, 64'h0000_0000_8080_7F7F, 2};
        vecs[3] = '{{32'd0, 32'd0, 32'hC000_0000, 32'h4000_0000, 32'hFFFF_FFFD, 32'd3, 32'h8000_0000, 32'h7FFF_FFFF},
                    5'd31, 1'b0, 64'h0000_0001_0000_FF01, 0};
        vecs[4] = '{{32'hFFFF_F7F8, 32'd2047, 32'hFFFF_FFE8, 32'd24, 32'hFFFF_FFF7, 32'hFFFF_FFF8, 32'd7, 32'd8},
                    5'd4, 1'b0, 64'h807F_FF02_FF00_0001, 1};

        idle();
        bus.dst_ready = 1'b0;
        #1;
        do_reset();

        // Table: single beats, latency of three edges, packed word and saturation count.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            bus.dst_ready = 1'b1;
            enable = 1'b1;
            drive(1'b1, vecs[v].lanes, vecs[v].shift, vecs[v].relu);
            step();
            idle();
            chk("tbl_lat_edge1", bus.dst_valid, 0);
            step();
            chk("tbl_lat_edge2", bus.dst_valid, 0);
            step();
            chk("tbl_lat_edge3", bus.dst_valid, 1);
            chk("tbl_data", bus.dst_data, vecs[v].data);
            chk("tbl_sat", sat_cnt, 64'(vecs[v].sat));
        end

        // Overflow: five beats into a stalled 4-deep FIFO.
        do_reset();
        enable = 1'b1;
        bus.dst_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            l = '0;
            l[0] = 32'(k);
            drive(1'b1, l, 5'd0, 1'b0);
            step();
        end
        idle();
        step();
        step();
        chk("ovf_flag", overflow, 1);
        chk("ovf_held_valid", bus.dst_valid, 1);
        bus.dst_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("ovf_pop", bus.dst_data, 64'(k));
            step();
        end
        chk("ovf_drained", bus.dst_valid, 0);
        chk("ovf_sticky", overflow, 1);

        // Full FIFO with simultaneous push/pop, then toggling ready and an enable gap.
        do_reset();
        popped.delete();
        exp_ids.delete();
        enable = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            bus.dst_ready = (k >= 7);
            l = '0;
            l[0] = 32'(k);
            drive(1'b1, l, 5'd0, 1'b0);
            exp_ids.push_back(k);
            step();
        end
        idle();
        bus.dst_ready = 1'b1;
        repeat (8) step();
        for (int c = 0; c < 8; c++) begin
            bus.dst_ready = (c % 2 == 0);
            enable = !(c == 2 || c == 3);
            l = '0;
            l[0] = 32'(11 + c);
            drive(1'b1, l, 5'd0, 1'b0);
            if (enable) exp_ids.push_back(11 + c);
            step();
        end
        enable = 1'b1;
        idle();
        bus.dst_ready = 1'b1;
        repeat (8) step();
        chk("pp_overflow", overflow, 0);
        chk("pp_count", 64'(popped.size()), 64'(exp_ids.size()));
        for (int i = 0; i < exp_ids.size(); i++) begin
            if (i < popped.size()) chk("pp_order", popped[i], 64'(exp_ids[i]));
        end

        // Reset with three buffered entries and a beat in S2.
        do_reset();
        enable = 1'b1;
        bus.dst_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            l = '0;
            l[0] = 32'd1000;
            l[1] = 32'(k);
            drive(1'b1, l, 5'd0, 1'b0);
            step();
        end
        idle();
        chk("mid_pre_valid", bus.dst_valid, 1);
        chk("mid_pre_sat", sat_cnt, 3);
        do_reset();
        bus.dst_ready = 1'b1;
        l = '0;
        l[0] = 32'd7;
        drive(1'b1, l, 5'd0, 1'b0);
        step();
        idle();
        chk("mid_lat_edge1", bus.dst_valid, 0);
        step();
        chk("mid_lat_edge2", bus.dst_valid, 0);
        step();
        chk("mid_lat_edge3", bus.dst_valid, 1);
        chk("mid_fresh_data", bus.dst_data, 64'd7);

        // Randomized traffic against the model, with a reset part-way through.
        do_reset();
        rdy_pct = 50;
        for (int c = 0; c < 1500; c++) begin
            if (c % 100 == 0) rdy_pct = $urandom_range(10, 100);
            if (c == 700) do_reset();
            enable = ($urandom_range(0, 7) != 0);
            bus.dst_ready = ($urandom_range(1, 100) <= rdy_pct);
            for (int i = 0; i < 8; i++) l[i] = rnd_lane();
            drive($urandom_range(0, 3) != 0, l, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            step();
        end

        // Saturation counter clamps at all-ones.
        do_reset();
        enable = 1'b1;
        bus.dst_ready = 1'b1;
        for (int i = 0; i < 8; i++) l[i] = 32'h7FFF_FFFF;
        drive(1'b1, l, 5'd0, 1'b0);
        repeat (8200) step();
        idle();
        step();
        step();
        chk("sat_clamp", sat_cnt, 64'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
